svnseg_capture: RTL

SVNSEG_CAPTURE -- requirements
Module: svnseg_capture

---
 rtl/svnseg_pkg.sv | 50 +++++
 rtl/svnseg_decode.sv | 23 ++
 rtl/svnseg_capture.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/svnseg_pkg.sv
// Shared seven-segment definitions: hex glyph patterns (active-high, bit6=a .. bit0=g),
// the blank pattern and the capture sampler state encoding.
package svnseg_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNT    = 2'd1,
        ST_CAPTURED = 2'd2
    } sampler_state_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] value);
        case (value)
            4'h0: seg_encode = SEG_0;
            4'h1: seg_encode = SEG_1;
            4'h2: seg_encode = SEG_2;
            4'h3: seg_encode = SEG_3;
            4'h4: seg_encode = SEG_4;
            4'h5: seg_encode = SEG_5;
            4'h6: seg_encode = SEG_6;
            4'h7: seg_encode = SEG_7;
            4'h8: seg_encode = SEG_8;
            4'h9: seg_encode = SEG_9;
            4'hA: seg_encode = SEG_A;
            4'hB: seg_encode = SEG_B;
            4'hC: seg_encode = SEG_C;
            4'hD: seg_encode = SEG_D;
            4'hE: seg_encode = SEG_E;
            default: seg_encode = SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/svnseg_decode.sv
// Combinational seven-segment decoder: active-high pattern -> {hit, blank, value}.
module svnseg_decode
    import svnseg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       hit_o,
    output logic       blank_o,
    output logic [3:0] value_o
);

    always_comb begin
        hit_o   = 1'b0;
        value_o = 4'h0;
        blank_o = (pattern_i == SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (pattern_i == seg_encode(4'(i))) begin
                hit_o   = 1'b1;
                value_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/svnseg_capture.sv
// Recovers hex digits from a multiplexed active-low seven-segment display bus.
// Optional per-digit staleness timeout: define SVNSEG_CAPTURE_TIMEOUT_EN.
module svnseg_capture
    import svnseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] digit,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    update,
    output sampler_state_t          fsm_state_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]            pat;
    logic [NUM_DIGITS-1:0] act;
    logic                  one_hot;
    logic [IDX_W-1:0]      idx;

    // Inputs are asynchronous to us in practice; all decisions use the registered copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= '1;
            an_q  <= '1;
        end else begin
            seg_q <= seg_n;
            an_q  <= an_n;
        end
    end

    always_comb begin
        pat     = ~seg_q;
        act     = ~an_q;
        one_hot = (act != '0) && ((act & (act - NUM_DIGITS'(1))) == '0);
        idx     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (act[i]) idx = IDX_W'(i);
        end
    end

    sampler_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       ref_seg_q, ref_seg_d;
    logic [IDX_W-1:0] ref_idx_q, ref_idx_d;
    logic             match;
    logic             capture;

    assign match = (pat == ref_seg_q) && (idx == ref_idx_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ref_seg_q <= '0;
            ref_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_seg_q <= ref_seg_d;
            ref_idx_q <= ref_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ref_seg_d = ref_seg_q;
        ref_idx_d = ref_idx_q;
        if (!one_hot) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == ST_CAPTURED && match) begin
            state_d = ST_CAPTURED;
        end else if (state_q == ST_COUNT && match) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_d == STABLE_CNT) ? ST_CAPTURED : ST_COUNT;
        end else begin
            cnt_d     = CNT_W'(1);
            ref_seg_d = pat;
            ref_idx_d = idx;
            state_d   = (STABLE_CYCLES == 1) ? ST_CAPTURED : ST_COUNT;
        end
    end

    // A capture is any edge that enters CAPTURED, but not one that merely holds it.
    always_comb begin
        capture     = (state_d == ST_CAPTURED) && !(state_q == ST_CAPTURED && match);
        fsm_state_o = state_q;
    end

    logic       dec_hit;
    logic       dec_blank;
    logic [3:0] dec_value;

    svnseg_decode u_decode (
        .pattern_i (pat),
        .hit_o     (dec_hit),
        .blank_o   (dec_blank),
        .value_o   (dec_value)
    );

    logic [4*NUM_DIGITS-1:0] digit_q, digit_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic                    update_q, update_d;

`ifdef SVNSEG_CAPTURE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_q [NUM_DIGITS];
    logic [TMO_W-1:0] tmo_d [NUM_DIGITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) tmo_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) tmo_q[i] <= tmo_d[i];
        end
    end
`else
    if (TIMEOUT_CYCLES > 0) begin : g_no_timeout
    end
`endif

    always_comb begin
        digit_d = digit_q;
        valid_d = valid_q;
        err_d   = err_q;
`ifdef SVNSEG_CAPTURE_TIMEOUT_EN
        // Counters saturate, so the timeout fires once per capture.
        for (int i = 0; i < NUM_DIGITS; i++) begin
            tmo_d[i] = tmo_q[i];
            if (capture && idx == IDX_W'(i)) begin
                tmo_d[i] = '0;
            end else if (tmo_q[i] != TMO_MAX) begin
                tmo_d[i] = tmo_q[i] + TMO_W'(1);
                if (tmo_d[i] == TMO_MAX) valid_d[i] = 1'b0;
            end
        end
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && idx == IDX_W'(i)) begin
                if (dec_hit) begin
                    digit_d[4*i +: 4] = dec_value;
                    valid_d[i]        = 1'b1;
                end else if (dec_blank) begin
                    valid_d[i] = 1'b0;
                end else begin
                    err_d[i] = 1'b1;
                end
            end
        end
        update_d = (digit_d != digit_q) || (valid_d != valid_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q  <= '0;
            valid_q  <= '0;
            err_q    <= '0;
            update_q <= 1'b0;
        end else begin
            digit_q  <= digit_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            update_q <= update_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = valid_q;
    assign digit_err   = err_q;
    assign update      = update_q;

endmodule
